// File: rtl/octa16_pkg.sv
// Shared types and defaults for the octa16 byte packer.
package octa16_pkg;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } pack_state_e;

  localparam int DEFAULT_SYNC_STAGES    = 2;
  localparam int DEFAULT_FIFO_DEPTH     = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/octa16_sync_edge.sv
// Synchronizes an asynchronous strobe and flags its rising edge for one cycle.
// Free-running: these flops never stall, so a disabled core sees no stale edge later.
module octa16_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/octa16_byte_packer.sv
// Packs strobed bytes into 16-bit words {high, low} and queues them in a small FIFO.
// Optional half-word abandon timer is compiled in with OCTA16_PACK_TIMEOUT_EN.
module octa16_byte_packer
  import octa16_pkg::*;
#(
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  byte_in,
  input  logic        byte_stb,
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [1:0]  fifo_level,
  output logic        half_pending,
  output logic        err_overrun,
  output logic        err_timeout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  pack_state_e     state_q, state_d;
  logic [7:0]      lo_q, lo_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovr_q, ovr_d;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic stb_rise;
  logic capture;
  logic complete;
  logic not_empty;
  logic full;
  logic pop;
  logic push;
  logic to_fire;

  octa16_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (byte_stb),
    .rise_o  (stb_rise)
  );

  assign capture   = ena & stb_rise;
  assign complete  = capture & (state_q == HIGH);
  assign not_empty = (count_q != '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = ena & not_empty & word_ready;
  // On a full FIFO the word fits only if the head leaves on the same edge.
  assign push      = complete & (~full | pop);

`ifdef OCTA16_PACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_to_q;

  always_comb begin
    to_fire  = ena & (state_q == HIGH) & ~capture &
               (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    to_cnt_d = to_cnt_q;
    if (ena) begin
      if ((state_q != HIGH) || capture || to_fire) begin
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_to_q <= to_fire;
    end
  end

  assign err_timeout = err_to_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign to_fire            = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    if (capture) begin
      if (state_q == LOW) begin
        state_d = HIGH;
        lo_d    = byte_in;
      end else begin
        state_d = LOW;
      end
    end else if (to_fire) begin
      state_d = LOW;
      lo_d    = 8'h00;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q | (complete & full & ~pop);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOW;
      lo_q     <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
    end
  end

  // Storage needs no reset: word_out is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {byte_in, lo_q};
    end
  end

  assign word_out     = not_empty ? mem_q[rd_ptr_q] : 16'h0000;
  assign word_valid   = not_empty;
  assign fifo_level   = (count_q >= CW'(3)) ? 2'd3 : 2'(count_q);
  assign half_pending = (state_q == HIGH);
  assign err_overrun  = ovr_q;

endmodule
